// File: rtl/div_sequencer_pkg.sv
// Shared constants for the divide sequencer: ALU select codes, FSM encodings
// and the decode of a select code into divide-operation flags.
package div_sequencer_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int DIV_ITERS    = XLEN_DEFAULT;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_DIV  = 5'd20;
    localparam logic [4:0] ALU_DIVU = 5'd21;
    localparam logic [4:0] ALU_REM  = 5'd22;
    localparam logic [4:0] ALU_REMU = 5'd23;

    localparam logic [1:0] DIVST_IDLE = 2'd0;
    localparam logic [1:0] DIVST_BUSY = 2'd1;
    localparam logic [1:0] DIVST_DONE = 2'd2;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic want_rem;
    } div_op_t;

    function automatic div_op_t decode_op(input logic [4:0] sel);
        div_op_t op;
        case (sel)
            ALU_DIV:  op = '{is_div: 1'b1, is_signed: 1'b1, want_rem: 1'b0};
            ALU_DIVU: op = '{is_div: 1'b1, is_signed: 1'b0, want_rem: 1'b0};
            ALU_REM:  op = '{is_div: 1'b1, is_signed: 1'b1, want_rem: 1'b1};
            ALU_REMU: op = '{is_div: 1'b1, is_signed: 1'b0, want_rem: 1'b1};
            default:  op = '{is_div: 1'b0, is_signed: 1'b0, want_rem: 1'b0};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide handshake: request from the pipeline, stall/result back.
interface div_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic [4:0]      alusel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, alusel, op_a, op_b, flush,
                    input  stall, busy, done, result);
    modport slave  (input  start, alusel, op_a, op_b, flush,
                    output stall, busy, done, result);
endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring divide step; the remainder keeps its carry-out bit so
// divisors with the MSB set are handled correctly.
module div_restoring_step #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dvd_next
);
    logic [XLEN:0] rem_ext_s;

    // Trial subtraction and quotient-bit insertion
    always_comb begin
        rem_ext_s = {rem, dvd[XLEN-1]};
        if (rem_ext_s >= {1'b0, divisor}) begin
            rem_next = rem_ext_s[XLEN-1:0] - divisor;
            dvd_next = {dvd[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_ext_s[XLEN-1:0];
            dvd_next = {dvd[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside the EX-stage ALU; stalls the
// front of the pipeline while iterating and pulses done with the result.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    div_sequencer_if.slave  bus
);
    localparam int CW    = $clog2(XLEN) + 1;
    localparam int ITERS = XLEN;

    logic [1:0]      state_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] rem_r, dvd_r, dvs_r, result_r;
    logic            neg_q_r, neg_r_r, is_signed_r, want_rem_r;

    div_op_t         op_s;
    logic            accept_s, zero_div_s, ovf_s, stall_s;
    logic [XLEN-1:0] min_s, abs_a_s, abs_b_s;
    logic [XLEN-1:0] rem_nxt_s, dvd_nxt_s, final_s;

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .divisor  (dvs_r),
        .rem_next (rem_nxt_s),
        .dvd_next (dvd_nxt_s)
    );

    // Request decode, special-case detection and pipeline stall
    always_comb begin
        op_s       = decode_op(bus.alusel);
        accept_s   = (state_r == DIVST_IDLE) && bus.start && op_s.is_div && !bus.flush;
        min_s      = {1'b1, {(XLEN-1){1'b0}}};
        zero_div_s = (bus.op_b == {XLEN{1'b0}});
        ovf_s      = op_s.is_signed && (bus.op_a == min_s) && (bus.op_b == {XLEN{1'b1}});
        abs_a_s    = (op_s.is_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
        abs_b_s    = (op_s.is_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
        stall_s    = accept_s || (state_r == DIVST_BUSY);
    end

    // Sign fix-up of the final step's quotient or remainder
    always_comb begin
        if (want_rem_r) begin
            final_s = (is_signed_r && neg_r_r) ? -rem_nxt_s : rem_nxt_s;
        end else begin
            final_s = (is_signed_r && neg_q_r) ? -dvd_nxt_s : dvd_nxt_s;
        end
    end

    // Sequencer state, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= DIVST_IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= {XLEN{1'b0}};
            dvd_r       <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            is_signed_r <= 1'b0;
            want_rem_r  <= 1'b0;
        end else begin
            case (state_r)
                DIVST_IDLE: begin
                    if (accept_s) begin
                        is_signed_r <= op_s.is_signed;
                        want_rem_r  <= op_s.want_rem;
                        neg_q_r     <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
                        neg_r_r     <= bus.op_a[XLEN-1];
                        if (zero_div_s) begin
                            result_r <= op_s.want_rem ? bus.op_a : {XLEN{1'b1}};
                            state_r  <= DIVST_DONE;
                        end else if (ovf_s) begin
                            result_r <= op_s.want_rem ? {XLEN{1'b0}} : min_s;
                            state_r  <= DIVST_DONE;
                        end else begin
                            rem_r   <= {XLEN{1'b0}};
                            dvd_r   <= abs_a_s;
                            dvs_r   <= abs_b_s;
                            cnt_r   <= {CW{1'b0}};
                            state_r <= DIVST_BUSY;
                        end
                    end else begin
                        state_r <= DIVST_IDLE;
                    end
                end
                DIVST_BUSY: begin
                    if (bus.flush) begin
                        state_r <= DIVST_IDLE;
                    end else begin
                        rem_r <= rem_nxt_s;
                        dvd_r <= dvd_nxt_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(ITERS - 1)) begin
                            result_r <= final_s;
                            state_r  <= DIVST_DONE;
                        end else begin
                            state_r <= DIVST_BUSY;
                        end
                    end
                end
                DIVST_DONE: state_r <= DIVST_IDLE;
                default:    state_r <= DIVST_IDLE;
            endcase
        end
    end

    assign bus.stall  = stall_s;
    assign bus.busy   = (state_r != DIVST_IDLE);
    assign bus.done   = (state_r == DIVST_DONE);
    assign bus.result = result_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    div_sequencer_if #(.XLEN(32)) bus();

    div_sequencer #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (sel)
            ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 32'd0) ? a : a % b;
            ALU_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            ALU_REM:  return (b == 32'd0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((sel == ALU_DIV || sel == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp_res;
        int exp_lat, cyc;
        bit got, stall_ok;
        exp_res = model(sel, a, b);
        exp_lat = model_lat(sel, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.alusel = sel; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL %s stall_c0 got=%b exp=1", name, bus.stall); end
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; got = 0; stall_ok = 1;
        while (cyc < 45 && !got) begin
            #1;
            if (bus.done === 1'b1) begin
                got = 1;
                total++;
                if (cyc != exp_lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, exp_lat); end
                total++;
                if (bus.result !== exp_res) begin bad++; $display("FAIL %s result got=%h exp=%h", name, bus.result, exp_res); end
                total++;
                if (bus.stall !== 1'b0) begin bad++; $display("FAIL %s stall_done got=%b exp=0", name, bus.stall); end
            end else begin
                if (bus.stall !== 1'b1) stall_ok = 0;
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (!got) begin bad++; $display("FAIL %s timeout cycles=%0d exp_lat=%0d", name, cyc, exp_lat); end
        total++;
        if (!stall_ok) begin bad++; $display("FAIL %s stall_busy got=0 exp=1", name); end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.alusel = ALU_ADD; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'd0) begin
            bad++; $display("FAIL reset busy=%b done=%b stall=%b result=%h exp=0,0,0,0", bus.busy, bus.done, bus.stall, bus.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        do_op(ALU_DIVU, 32'd100, 32'd7, "divu_100_7");
        do_op(ALU_REMU, 32'd100, 32'd7, "remu_100_7");
        do_op(ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
        do_op(ALU_REMU, 32'hFFFF_FFFF, 32'h8000_0001, "remu_big");
    endtask

    task automatic test_signed();
        do_op(ALU_DIV, 32'hFFFF_FFEC, 32'd3, "div_m20_3");
        do_op(ALU_REM, 32'hFFFF_FFEC, 32'd3, "rem_m20_3");
        do_op(ALU_DIV, 32'd20, 32'hFFFF_FFFD, "div_20_m3");
        do_op(ALU_REM, 32'd20, 32'hFFFF_FFFD, "rem_20_m3");
    endtask

    task automatic test_special();
        do_op(ALU_DIVU, 32'd5, 32'd0, "divu_by0");
        do_op(ALU_REM, 32'd5, 32'd0, "rem_by0");
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd0, "div_m7_by0");
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    endtask

    task automatic test_random();
        logic [4:0]  sel;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(3, 0))
                0: sel = ALU_DIV;
                1: sel = ALU_DIVU;
                2: sel = ALU_REM;
                default: sel = ALU_REMU;
            endcase
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(9, 1)) : $urandom;
            do_op(sel, a, b, "random");
        end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        bit saw_done;
        do_op(ALU_DIVU, 32'd77, 32'd5, "pre_flush");
        held = 32'd15;
        @(negedge clk);
        bus.start = 1'b1; bus.alusel = ALU_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_cycle stall got=%b exp=1", bus.stall); end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL flush_idle busy=%b stall=%b exp=0,0", bus.busy, bus.stall); end
        saw_done = 0;
        repeat (40) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1; end
        total++;
        if (saw_done) begin bad++; $display("FAIL flush_nodone got=1 exp=0"); end
        total++;
        if (bus.result !== held) begin bad++; $display("FAIL flush_result got=%h exp=%h", bus.result, held); end
        do_op(ALU_DIVU, 32'd9, 32'd2, "after_flush");
        @(negedge clk);
        bus.start = 1'b1; bus.alusel = ALU_DIV; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.flush = 1'b1;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_start stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_non_div();
        @(negedge clk);
        bus.start = 1'b1; bus.alusel = ALU_ADD; bus.op_a = 32'd3; bus.op_b = 32'd4;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin bad++; $display("FAIL nondiv stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL nondiv busy=%b done=%b exp=0,0", bus.busy, bus.done); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.alusel = ALU_DIVU; bus.op_a = 32'd500; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            bad++; $display("FAIL async_rst busy=%b stall=%b done=%b result=%h exp=0,0,0,0", bus.busy, bus.stall, bus.done, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(ALU_REMU, 32'd23, 32'd4, "after_rst");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_random();
        test_flush();
        test_non_div();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
